datapath: RTL and testbench

- 32-bit single-bus CPU datapath for the Phase-1 processor.
- Contains 16 general registers R0–R15, PC, HI, LO, Y, 64-bit Z, MAR, MDR, an input-port register and a combinational ALU, all joined by one shared 32-bit bus.
- Control signals are driven externally, by a testbench now and the control unit later. Each `*in` strobe loads a register at a clock edge. Each `*out` strobe selects the bus source.

---
 rtl/datapath_pkg.sv | 20 ++
 rtl/datapath_alu.sv | 48 ++++
 rtl/datapath.sv | 118 +++++++++++
 tb/tb_datapath.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/datapath_pkg.sv
// Shared definitions for the single-bus CPU datapath: bus width and ALU opcodes.
package datapath_pkg;

  localparam int WIDTH = 32;

  localparam logic [4:0] ADD  = 5'b00011;
  localparam logic [4:0] SUB  = 5'b00100;
  localparam logic [4:0] AND  = 5'b00101;
  localparam logic [4:0] OR   = 5'b00110;
  localparam logic [4:0] ROR  = 5'b00111;
  localparam logic [4:0] ROL  = 5'b01000;
  localparam logic [4:0] SHR  = 5'b01001;
  localparam logic [4:0] SHRA = 5'b01010;
  localparam logic [4:0] SHL  = 5'b01011;
  localparam logic [4:0] DIV  = 5'b01111;
  localparam logic [4:0] MUL  = 5'b10000;
  localparam logic [4:0] NEG  = 5'b10001;
  localparam logic [4:0] NOT  = 5'b10010;

endpackage

// File: rtl/datapath_alu.sv
// Combinational ALU: A comes from Y, B from the bus, 64-bit result feeds Z.
// Only MUL and DIV produce a non-zero upper half.
module alu
  import datapath_pkg::*;
(
  input  logic [4:0]         opcode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] c
);

  logic [4:0]                shamt;
  logic [5:0]                shinv;
  logic signed [2*WIDTH-1:0] prod;
  logic signed [WIDTH-1:0]   quo;
  logic signed [WIDTH-1:0]   rem;

  assign shamt = b[4:0];
  // Complementary shift for rotates; 32 when shamt is 0 so that half shifts out to zero.
  assign shinv = 6'd32 - {1'b0, shamt};
  assign prod  = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
  // Division truncates toward zero and the remainder follows the sign of the dividend.
  assign quo   = $signed(a) / $signed(b);
  assign rem   = $signed(a) % $signed(b);

  // Select the result for the current opcode.
  always_comb begin
    // NOTE: c gets a default before the case so no path leaves it unassigned (no latch).
    c = '0;
    case (opcode)
      ADD:  c[WIDTH-1:0] = a + b;
      SUB:  c[WIDTH-1:0] = a - b;
      AND:  c[WIDTH-1:0] = a & b;
      OR:   c[WIDTH-1:0] = a | b;
      ROR:  c[WIDTH-1:0] = (a >> shamt) | (a << shinv);
      ROL:  c[WIDTH-1:0] = (a << shamt) | (a >> shinv);
      SHR:  c[WIDTH-1:0] = a >> shamt;
      SHRA: c[WIDTH-1:0] = $signed(a) >>> shamt;
      SHL:  c[WIDTH-1:0] = a << shamt;
      DIV:  if (b != '0) c = {rem, quo};
      MUL:  c = prod;
      NEG:  c[WIDTH-1:0] = '0 - b;
      NOT:  c[WIDTH-1:0] = ~b;
      default: c = '0;
    endcase
  end

endmodule

// File: rtl/datapath.sv
// Single-bus 32-bit datapath: register file, special registers, bus mux and ALU.
// Every *in strobe loads at the rising clock edge; *out strobes pick the bus source.
module datapath
  import datapath_pkg::*;
(
  input  logic             clock,
  input  logic             clear,
  input  logic             R0in,  R1in,  R2in,  R3in,  R4in,  R5in,  R6in,  R7in,
  input  logic             R8in,  R9in,  R10in, R11in, R12in, R13in, R14in, R15in,
  input  logic             PCin,
  input  logic             HIin,
  input  logic             LOin,
  input  logic             Yin,
  input  logic             MARin,
  input  logic             Zin,
  input  logic             MDRin,
  input  logic             read,
  input  logic             incPC,
  input  logic             InPortIn,
  input  logic [4:0]       opcode,
  input  logic [WIDTH-1:0] Mdatain,
  input  logic [WIDTH-1:0] inport_data,
  input  logic             R0out, R1out, R2out,  R3out,  R4out,  R5out,  R6out,  R7out,
  input  logic             R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out,
  input  logic             PCout,
  input  logic             HIout,
  input  logic             LOout,
  input  logic             ZHighOut,
  input  logic             ZLowOut,
  input  logic             MDRout,
  input  logic             InPortOut,
  output logic [WIDTH-1:0] bus_out,
  output logic [WIDTH-1:0] mar_out
);

  logic [15:0]          r_in;
  logic [15:0]          r_out;
  logic [WIDTH-1:0]     r_q [16];
  logic [WIDTH-1:0]     pc_q, pc_d;
  logic [WIDTH-1:0]     hi_q, lo_q, y_q, mar_q, inport_q;
  logic [WIDTH-1:0]     mdr_q, mdr_d;
  logic [2*WIDTH-1:0]   z_q;
  logic [2*WIDTH-1:0]   alu_c;
  logic [WIDTH-1:0]     bus;

  assign r_in  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                  R7in,  R6in,  R5in,  R4in,  R3in,  R2in,  R1in, R0in};
  assign r_out = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                  R7out,  R6out,  R5out,  R4out,  R3out,  R2out,  R1out, R0out};

  // Bus mux: sources are applied lowest priority first so the highest-priority strobe wins.
  always_comb begin
    // NOTE: combinational logic uses blocking '=' so later statements see earlier results.
    bus = '0;
    if (InPortOut) bus = inport_q;
    if (MDRout)    bus = mdr_q;
    if (PCout)     bus = pc_q;
    if (ZLowOut)   bus = z_q[WIDTH-1:0];
    if (ZHighOut)  bus = z_q[2*WIDTH-1:WIDTH];
    if (LOout)     bus = lo_q;
    if (HIout)     bus = hi_q;
    for (int i = 15; i >= 0; i--) begin
      if (r_out[i]) bus = r_q[i];
    end
  end

  // Next PC: increment wins over a bus load and wraps naturally at 2^32.
  always_comb begin
    pc_d = pc_q;
    if (incPC)     pc_d = pc_q + 1'b1;
    else if (PCin) pc_d = bus;
  end

  // Next MDR: memory read data or the bus, selected by read.
  always_comb begin
    mdr_d = mdr_q;
    if (MDRin) mdr_d = read ? Mdatain : bus;
  end

  alu u_alu (
    .opcode (opcode),
    .a      (y_q),
    .b      (bus),
    .c      (alu_c)
  );

  // All datapath state: synchronous clear overrides every load strobe.
  always_ff @(posedge clock) begin
    if (clear) begin
      // NOTE: the register file is cleared too, so it maps to flops rather than a RAM macro.
      for (int i = 0; i < 16; i++) r_q[i] <= '0;
      pc_q     <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      y_q      <= '0;
      z_q      <= '0;
      mar_q    <= '0;
      mdr_q    <= '0;
      inport_q <= '0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (r_in[i]) r_q[i] <= bus;
      end
      pc_q  <= pc_d;
      mdr_q <= mdr_d;
      if (HIin)     hi_q     <= bus;
      if (LOin)     lo_q     <= bus;
      if (Yin)      y_q      <= bus;
      if (Zin)      z_q      <= alu_c;
      if (MARin)    mar_q    <= bus;
      if (InPortIn) inport_q <= inport_data;
    end
  end

  assign bus_out = bus;
  assign mar_out = mar_q;

endmodule

// File: tb/tb_datapath.sv
// Directed bench for the datapath: expected values go into a scoreboard queue when
// the stimulus is applied and are popped when the matching output is observed.
module tb_datapath;
  import datapath_pkg::*;

  logic        clock = 1'b0;
  logic        clear;
  logic [15:0] rin, rout;
  logic        PCin, HIin, LOin, Yin, MARin, Zin, MDRin, read, incPC, InPortIn;
  logic        PCout, HIout, LOout, ZHighOut, ZLowOut, MDRout, InPortOut;
  logic [4:0]  opcode;
  logic [31:0] Mdatain, inport_data;
  logic [31:0] bus_out, mar_out;

  logic [31:0] sb[$];
  int          compared   = 0;
  int          mismatched = 0;

  always #5 clock = ~clock;

  datapath dut (
    .clock(clock), .clear(clear),
    .R0in(rin[0]),   .R1in(rin[1]),   .R2in(rin[2]),   .R3in(rin[3]),
    .R4in(rin[4]),   .R5in(rin[5]),   .R6in(rin[6]),   .R7in(rin[7]),
    .R8in(rin[8]),   .R9in(rin[9]),   .R10in(rin[10]), .R11in(rin[11]),
    .R12in(rin[12]), .R13in(rin[13]), .R14in(rin[14]), .R15in(rin[15]),
    .PCin(PCin), .HIin(HIin), .LOin(LOin), .Yin(Yin), .MARin(MARin), .Zin(Zin),
    .MDRin(MDRin), .read(read), .incPC(incPC), .InPortIn(InPortIn),
    .opcode(opcode), .Mdatain(Mdatain), .inport_data(inport_data),
    .R0out(rout[0]),   .R1out(rout[1]),   .R2out(rout[2]),   .R3out(rout[3]),
    .R4out(rout[4]),   .R5out(rout[5]),   .R6out(rout[6]),   .R7out(rout[7]),
    .R8out(rout[8]),   .R9out(rout[9]),   .R10out(rout[10]), .R11out(rout[11]),
    .R12out(rout[12]), .R13out(rout[13]), .R14out(rout[14]), .R15out(rout[15]),
    .PCout(PCout), .HIout(HIout), .LOout(LOout), .ZHighOut(ZHighOut),
    .ZLowOut(ZLowOut), .MDRout(MDRout), .InPortOut(InPortOut),
    .bus_out(bus_out), .mar_out(mar_out)
  );

  task automatic idle();
    rin = '0; rout = '0;
    PCin = 0; HIin = 0; LOin = 0; Yin = 0; MARin = 0; Zin = 0; MDRin = 0;
    read = 0; incPC = 0; InPortIn = 0;
    PCout = 0; HIout = 0; LOout = 0; ZHighOut = 0; ZLowOut = 0; MDRout = 0; InPortOut = 0;
    opcode = '0;
  endtask

  // One clock edge, then release every strobe.
  task automatic step();
    @(posedge clock);
    #1;
    idle();
  endtask

  task automatic expect_val(input logic [31:0] v);
    sb.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    compared++;
    if (sb.size() == 0) begin
      mismatched++;
      $error("FAIL %s: observed %h but scoreboard is empty", tag, obs);
    end else begin
      exp = sb.pop_front();
      assert (obs === exp) else begin
        mismatched++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
    end
  endtask

  // Rn <= value through Mdatain -> MDR -> bus.
  task automatic load_reg(input int idx, input logic [31:0] val);
    Mdatain = val; read = 1; MDRin = 1;
    step();
    MDRout = 1; rin[idx] = 1;
    step();
  endtask

  task automatic obs_reg(input int idx, input string tag);
    rout[idx] = 1; #1; check(tag, bus_out); rout[idx] = 0;
  endtask

  task automatic obs_zlo(input string tag);
    ZLowOut = 1; #1; check(tag, bus_out); ZLowOut = 0;
  endtask

  task automatic obs_zhi(input string tag);
    ZHighOut = 1; #1; check(tag, bus_out); ZHighOut = 0;
  endtask

  // Y <= R[ra]; Z <= Y op R[rb]; then compare both halves of Z.
  task automatic alu_run(input int ra, input int rb, input logic [4:0] op,
                         input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                         input string tag);
    rout[ra] = 1; Yin = 1;
    step();
    rout[rb] = 1; opcode = op; Zin = 1;
    expect_val(exp_lo);
    expect_val(exp_hi);
    step();
    obs_zlo({tag, "_lo"});
    obs_zhi({tag, "_hi"});
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    Mdatain = '0; inport_data = '0;
    clear = 1;
    @(posedge clock); #1;
    clear = 0;

    // Reset: build up some state, then clear while loads are requested.
    load_reg(3, 32'h1234);
    expect_val(32'h1234); obs_reg(3, "r3_loaded");
    MDRout = 1; PCin = 1; MARin = 1; opcode = ADD; Zin = 1;
    step();
    expect_val(32'h1234); PCout = 1; #1; check("pc_loaded", bus_out); PCout = 0;
    expect_val(32'h1234); check("mar_loaded", mar_out);
    clear = 1; MDRout = 1; rin[3] = 1; PCin = 1; Zin = 1; MARin = 1;
    step();
    clear = 0;
    expect_val(0); obs_reg(3, "rst_r3");
    expect_val(0); PCout = 1; #1; check("rst_pc", bus_out); PCout = 0;
    expect_val(0); obs_zlo("rst_zlo");
    expect_val(0); MDRout = 1; #1; check("rst_mdr", bus_out); MDRout = 0;
    expect_val(0); check("rst_mar", mar_out);

    // MUL: -5 * 25 = -125, full 64-bit product through LO/HI.
    load_reg(2, 32'hFFFF_FFFB);
    load_reg(6, 32'd25);
    rout[2] = 1; Yin = 1; step();
    rout[6] = 1; opcode = MUL; Zin = 1; step();
    ZLowOut = 1; LOin = 1; step();
    ZHighOut = 1; HIin = 1; step();
    expect_val(32'hFFFF_FF83); LOout = 1; #1; check("mul_lo", bus_out); LOout = 0;
    expect_val(32'hFFFF_FFFF); HIout = 1; #1; check("mul_hi", bus_out); HIout = 0;

    // ADD wraps, SUB goes negative.
    load_reg(1, 32'hFFFF_FFFF);
    load_reg(4, 32'd2);
    alu_run(1, 4, ADD, 32'h0000_0001, 32'h0, "add_wrap");
    load_reg(5, 32'd5);
    load_reg(7, 32'd7);
    alu_run(5, 7, SUB, 32'hFFFF_FFFE, 32'h0, "sub");

    // DIV: -7 / 2 = -3 rem -1; divide by zero clears Z.
    load_reg(8, 32'hFFFF_FFF9);
    load_reg(2, 32'd2);
    alu_run(8, 2, DIV, 32'hFFFF_FFFD, 32'hFFFF_FFFF, "div");
    load_reg(9, 32'd0);
    alu_run(8, 9, DIV, 32'h0, 32'h0, "div0");

    // Shifts, rotates and logic on Y = 0x80000001, B = 1.
    load_reg(10, 32'h8000_0001);
    load_reg(11, 32'd1);
    alu_run(10, 11, SHRA, 32'hC000_0000, 32'h0, "shra");
    alu_run(10, 11, SHR,  32'h4000_0000, 32'h0, "shr");
    alu_run(10, 11, ROR,  32'hC000_0000, 32'h0, "ror");
    alu_run(10, 11, ROL,  32'h0000_0003, 32'h0, "rol");
    alu_run(10, 11, SHL,  32'h0000_0002, 32'h0, "shl");
    alu_run(10, 11, AND,  32'h0000_0001, 32'h0, "and");
    alu_run(10, 11, OR,   32'h8000_0001, 32'h0, "or");
    alu_run(10, 11, NEG,  32'hFFFF_FFFF, 32'h0, "neg");
    alu_run(10, 11, NOT,  32'hFFFF_FFFE, 32'h0, "not");
    alu_run(10, 11, 5'b00000, 32'h0, 32'h0, "bad_op");

    // PC wrap and MAR capture of the pre-edge PC; incPC beats PCin.
    Mdatain = 32'hFFFF_FFFF; read = 1; MDRin = 1; step();
    MDRout = 1; PCin = 1; step();
    PCout = 1; MARin = 1; incPC = 1; step();
    expect_val(32'hFFFF_FFFF); check("mar_old_pc", mar_out);
    expect_val(32'h0); PCout = 1; #1; check("pc_wrap", bus_out); PCout = 0;
    PCout = 1; MARin = 1; incPC = 1; PCin = 1; step();
    expect_val(32'h0); check("mar_pc0", mar_out);
    expect_val(32'h1); PCout = 1; #1; check("pc_inc_prio", bus_out); PCout = 0;

    // MDR loads from the bus when read is low.
    rout[10] = 1; MDRin = 1; read = 0; Mdatain = 32'hDEAD_BEEF; step();
    expect_val(32'h8000_0001); MDRout = 1; #1; check("mdr_from_bus", bus_out); MDRout = 0;

    // Bus priority and the idle bus.
    expect_val(32'hFFFF_FFFF);
    rout[1] = 1; MDRout = 1; #1; check("prio_r1_mdr", bus_out); idle();
    expect_val(32'hFFFF_FFFF);
    HIout = 1; LOout = 1; #1; check("prio_hi_lo", bus_out); idle();
    expect_val(32'h0); #1; check("bus_idle", bus_out);

    // Input port.
    inport_data = 32'h0000_00A5; InPortIn = 1; step();
    inport_data = 32'h0;
    expect_val(32'h0000_00A5); InPortOut = 1; #1; check("inport", bus_out); InPortOut = 0;

    if (sb.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
